responder_arbiter: RTL

- Quiz-buzzer arbitration stage, directly downstream of the 4-key debounce filter.
- Consumes one-cycle, active-high press pulses (one per player key) plus host start/clear pulses, which come through the same debounce path.
- Runs an answer-window countdown, latches the first player to press, locks out all others, and drives winner LEDs, a winner code, a seconds display value and a buzzer.

---
 rtl/responder_arbiter_if.sv | 23 ++
 rtl/responder_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/responder_arbiter_if.sv
// Handshake bundle between the debounce front end / host and the buzzer arbiter.
interface responder_arbiter_if;
  logic [3:0] key_pulse;
  logic       start_pulse;
  logic       clr_pulse;
  logic [3:0] led;
  logic [1:0] winner_id;
  logic       winner_vld;
  logic [3:0] countdown;
  logic       timeout;
  logic       foul;
  logic       buzzer;

  modport master (
    output key_pulse, start_pulse, clr_pulse,
    input  led, winner_id, winner_vld, countdown, timeout, foul, buzzer
  );

  modport slave (
    input  key_pulse, start_pulse, clr_pulse,
    output led, winner_id, winner_vld, countdown, timeout, foul, buzzer
  );
endinterface

// File: rtl/responder_arbiter.sv
// Quiz-buzzer arbiter: answer-window countdown, first-press lock, lockout and buzzer.
// Optional early-press foul detection is enabled by defining RESPONDER_FOUL_DETECT_EN.
module responder_arbiter #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned WINDOW_S = 10,
  parameter int unsigned BUZZ_MS  = 200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  responder_arbiter_if.slave   bus
);
  localparam int unsigned      CNT_W     = 32;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(CLK_HZ - 1);
  // Multiply before dividing so sub-kHz clocks still give a non-zero on-time.
  localparam logic [63:0]      BUZZ_PROD = (64'(CLK_HZ) * 64'(BUZZ_MS)) / 64'd1000;
  localparam logic [CNT_W-1:0] BUZZ_CYC  = CNT_W'(BUZZ_PROD);
  localparam logic             BUZZ_ON   = (BUZZ_CYC != '0);
  localparam logic [3:0]       WIN_LOAD  = 4'(WINDOW_S);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_LOCKED,
    S_TIMEOUT
`ifdef RESPONDER_FOUL_DETECT_EN
    , S_FOUL
`endif
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] tick_cnt;
  logic [CNT_W-1:0] buzz_cnt;
  logic [3:0]       led_q;
  logic [1:0]       id_q;
  logic             vld_q;
  logic [3:0]       cd_q;
  logic             to_q;
  logic             foul_q;
  logic             buzz_q;

  // Fixed priority: lowest-numbered pressing player wins a tie.
  function automatic logic [1:0] low_idx(input logic [3:0] k);
    if (k[0])      return 2'd0;
    else if (k[1]) return 2'd1;
    else if (k[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tick_cnt <= '0;
      buzz_cnt <= '0;
      led_q    <= '0;
      id_q     <= '0;
      vld_q    <= 1'b0;
      cd_q     <= '0;
      to_q     <= 1'b0;
      foul_q   <= 1'b0;
      buzz_q   <= 1'b0;
    end else if (bus.clr_pulse) begin
      state_q  <= S_IDLE;
      tick_cnt <= '0;
      buzz_cnt <= '0;
      led_q    <= '0;
      id_q     <= '0;
      vld_q    <= 1'b0;
      cd_q     <= '0;
      to_q     <= 1'b0;
      foul_q   <= 1'b0;
      buzz_q   <= 1'b0;
    end else begin
      // Buzzer on-time; an entry event below overrides this with a fresh start.
      if (buzz_q) begin
        if (buzz_cnt == BUZZ_CYC - 32'd1) begin
          buzz_q   <= 1'b0;
          buzz_cnt <= '0;
        end else begin
          buzz_cnt <= buzz_cnt + 32'd1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (bus.start_pulse) begin
            state_q  <= S_ARMED;
            cd_q     <= WIN_LOAD;
            tick_cnt <= '0;
          end
`ifdef RESPONDER_FOUL_DETECT_EN
          else if (|bus.key_pulse) begin
            state_q  <= S_FOUL;
            id_q     <= low_idx(bus.key_pulse);
            led_q    <= 4'b0001 << low_idx(bus.key_pulse);
            foul_q   <= 1'b1;
            buzz_q   <= BUZZ_ON;
            buzz_cnt <= '0;
          end
`endif
        end

        S_ARMED: begin
          // A press beats a coincident tick: countdown freezes, no timeout.
          if (|bus.key_pulse) begin
            state_q  <= S_LOCKED;
            id_q     <= low_idx(bus.key_pulse);
            led_q    <= 4'b0001 << low_idx(bus.key_pulse);
            vld_q    <= 1'b1;
            buzz_q   <= BUZZ_ON;
            buzz_cnt <= '0;
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            if (cd_q <= 4'd1) begin
              cd_q     <= '0;
              state_q  <= S_TIMEOUT;
              to_q     <= 1'b1;
              buzz_q   <= BUZZ_ON;
              buzz_cnt <= '0;
            end else begin
              cd_q <= cd_q - 4'd1;
            end
          end else begin
            tick_cnt <= tick_cnt + 32'd1;
          end
        end

        default: ;
      endcase
    end
  end

  assign bus.led        = led_q;
  assign bus.winner_id  = id_q;
  assign bus.winner_vld = vld_q;
  assign bus.countdown  = cd_q;
  assign bus.timeout    = to_q;
  assign bus.buzzer     = buzz_q;
`ifdef RESPONDER_FOUL_DETECT_EN
  assign bus.foul       = foul_q;
`else
  assign bus.foul       = 1'b0;
  logic unused_foul;
  assign unused_foul    = foul_q;
`endif

endmodule
